// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package nibble_serial_subtractor_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Nibble index width; a single-nibble datapath still needs one bit.
    function automatic int unsigned idx_w(input int unsigned nibs);
        return (nibs <= 1) ? 1 : $clog2(nibs);
    endfunction

endpackage

// File: rtl/nibble_serial_subtractor_borrow_skip4.sv
// One 4-bit subtract slice: ripple borrow chain plus a skip bypass when all bit pairs match.
module nibble_borrow_skip4
    import nibble_serial_subtractor_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             bin,
    output logic [NIB_W-1:0] d,
    output logic             bout,
    output logic             p
);

    logic ripple_c;

    always_comb begin
        d        = '0;
        ripple_c = bin;
        for (int i = 0; i < int'(NIB_W); i++) begin
            d[i]     = a[i] ^ b[i] ^ ripple_c;
            ripple_c = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & ripple_c);
        end
    end

    // Equal operands leave the incoming borrow untouched, so it can bypass the chain.
    assign p    = &(~(a ^ b));
    assign bout = p ? bin : ripple_c;

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle a - b - bin, one nibble per clock LSB first, with valid/ready on both sides.
module nibble_serial_subtractor
    import nibble_serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int unsigned NIBS  = WIDTH / NIB_W;
    localparam int unsigned IDX_W = idx_w(NIBS);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               br_q, br_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   wdiff_q, wdiff_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [NIB_W-1:0]   a_nib, b_nib, nib_d;
    logic               nib_bout, nib_p;

    // Working operands shift right so the active nibble is always the low one.
    assign a_nib = a_q[NIB_W-1:0];
    assign b_nib = b_q[NIB_W-1:0];

    nibble_borrow_skip4 u_nib (
        .a    (a_nib),
        .b    (b_nib),
        .bin  (br_q),
        .d    (nib_d),
        .bout (nib_bout),
        .p    (nib_p)
    );

    // A skipped nibble has equal operands, so every difference bit is the incoming borrow.
    always_comb begin
        if (state_q == RUN && nib_p) begin
            assert (nib_d == {NIB_W{br_q}});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            br_q        <= 1'b0;
            idx_q       <= '0;
            wdiff_q     <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            br_q        <= br_d;
            idx_q       <= idx_d;
            wdiff_q     <= wdiff_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        br_d     = br_q;
        idx_d    = idx_q;
        wdiff_d  = wdiff_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    idx_d   = '0;
                    wdiff_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> NIB_W;
                b_d     = b_q >> NIB_W;
                br_d    = nib_bout;
                idx_d   = idx_q + IDX_W'(1);
                // New nibble enters at the top; after NIBS steps it lands in place.
                wdiff_d = (wdiff_q >> NIB_W) | (WIDTH'(nib_d) << (WIDTH - NIB_W));
                if (idx_q == IDX_W'(NIBS - 1)) begin
                    diff_d   = wdiff_d;
                    borrow_d = nib_bout;
                    ovf_d    = (a_nib[NIB_W-1] != b_nib[NIB_W-1]) &&
                               (nib_d[NIB_W-1] != a_nib[NIB_W-1]);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed and random checks of the nibble-serial subtractor against an integer arithmetic model.
module tb_nibble_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         ovf;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] last_diff;
    logic         last_bo, last_ov;

    always #5 clk = ~clk;

    nibble_serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction, borrow as sign of the unsigned result, signed range test.
    function automatic void model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                  input logic tbin, output logic [W-1:0] d,
                                  output logic bo, output logic ov);
        int ur, sr;
        ur = int'(ta) - int'(tb) - int'(tbin);
        sr = int'($signed(ta)) - int'($signed(tb)) - int'(tbin);
        d  = W'(ur);
        bo = (ur < 0);
        ov = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE, wait for the result and check it; returns with DUT in DONE.
    task automatic start_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tbin, input bit chk_lat);
        logic [W-1:0] ed;
        logic         eb, eo;
        int           cnt;
        model(ta, tb, tbin, ed, eb, eo);
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        if (chk_lat) begin
            chk({tag, "_hold_diff"}, 32'(diff), 32'(last_diff));
            chk({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
        end
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            step();
            cnt++;
        end
        if (chk_lat) chk({tag, "_latency"}, 32'(cnt), 32'd2);
        else if (cnt >= 20) chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_borrow"}, 32'(borrow_out), 32'(eb));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        last_diff = ed; last_bo = eb; last_ov = eo;
    endtask

    task automatic finish_op(input string tag);
        step();
        chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
        last_diff = '0; last_bo = 1'b0; last_ov = 1'b0;
        step();
        step();
        chk("reset_ready", 32'(in_ready), 32'd1);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_diff", 32'(diff), 32'd0);
        chk("reset_flags", {30'd0, borrow_out, ovf}, 32'd0);
        rst = 1'b0;
        step();

        start_op("t35m12", 8'h35, 8'h12, 1'b0, 1'b1); finish_op("t35m12");
        start_op("t12m35", 8'h12, 8'h35, 1'b0, 1'b1); finish_op("t12m35");
        start_op("tAAskip", 8'hAA, 8'hAA, 1'b1, 1'b1); finish_op("tAAskip");
        start_op("t00m01", 8'h00, 8'h01, 1'b0, 1'b1); finish_op("t00m01");
        start_op("t80m01", 8'h80, 8'h01, 1'b0, 1'b1); finish_op("t80m01");
        start_op("t7FmFF", 8'h7F, 8'hFF, 1'b0, 1'b1); finish_op("t7FmFF");
        chk("direct_7F_diff", 32'(last_diff), 32'h80);

        // Result backpressure with ignored input pulses.
        out_ready = 1'b0;
        start_op("bp", 8'h5C, 8'hC5, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom);
            a = W'($urandom); b = W'($urandom);
            step();
            chk($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp_ready_%0d", i), 32'(in_ready), 32'd0);
            chk($sformatf("bp_diff_%0d", i), 32'(diff), 32'(last_diff));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        finish_op("bp");

        // Reset one cycle into RUN aborts without ever presenting a result.
        a = 8'h35; b = 8'h12; bin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_ready", 32'(in_ready), 32'd1);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        step();
        rst = 1'b0;
        last_diff = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("abort_quiet_%0d", i), 32'(out_valid), 32'd0);
        end

        for (int i = 0; i < 512; i++) begin
            start_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom), 1'($urandom), 1'b0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
